fifo_rd_ctrl: RTL

Read-side controller of the asynchronous FIFO, living entirely in the rclk domain. It consumes the 2-flop-synchronized Gray write pointer and owns the binary/Gray read pointer, the memory read address and the registered empty/almost-empty flags. It also owns a first-word-fall-through output register with a valid/ready handshake. Its Gray read pointer is the source that the write-side synchronizer samples into wclk.

---
 rtl/fifo_rd_ctrl.sv | 83 ++++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO (rclk domain): Gray/binary read pointer,
// registered empty/almost-empty/level flags and a first-word-fall-through output register.
module fifo_rd_ctrl #(
    parameter int unsigned ADDRSIZE  = 4,
    parameter int unsigned DATASIZE  = 8,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   rd_wptr,
    input  logic [DATASIZE-1:0] rdata_mem,
    input  logic                rd_ready,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [DATASIZE-1:0] rd_data,
    output logic                rd_valid,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0]       rbin;
    logic [PW-1:0]       rbin_next;
    logic [PW-1:0]       rgray_next;
    logic [PW-1:0]       wbin;
    logic [PW-1:0]       level_next;
    logic                pop;
    logic                valid_next;
    logic [DATASIZE-1:0] data_next;
    logic                empty_next;
    logic                aempty_next;

    // Next-state: pop decision, pointer advance, output register and flag values
    always_comb begin
        pop        = !rempty && (!rd_valid || rd_ready);
        rbin_next  = rbin + PW'(pop);
        rgray_next = (rbin_next >> 1) ^ rbin_next;

        // Gray-to-binary as an XOR of all right shifts (prefix from the MSB)
        wbin = rd_wptr;
        for (int unsigned s = 1; s < PW; s++) begin
            wbin = wbin ^ (rd_wptr >> s);
        end

        valid_next = rd_valid;
        data_next  = rd_data;
        if (pop) begin
            valid_next = 1'b1;
            data_next  = rdata_mem;
        end else if (rd_valid && rd_ready) begin
            valid_next = 1'b0;
        end

        empty_next  = (rgray_next == rd_wptr);
        level_next  = (wbin - rbin_next) + PW'(valid_next);
        aempty_next = (level_next <= PW'(AEMPTY_TH));
    end

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            rbin     <= '0;
            rptr     <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rempty   <= 1'b1;
            raempty  <= 1'b1;
            rlevel   <= '0;
        end else begin
            rbin     <= rbin_next;
            rptr     <= rgray_next;
            rd_data  <= data_next;
            rd_valid <= valid_next;
            rempty   <= empty_next;
            raempty  <= aempty_next;
            rlevel   <= level_next;
        end
    end

    assign raddr = rbin[ADDRSIZE-1:0];

endmodule
